retospect_lif_core: RTL and testbench
=====================================

RETOSPECT_LIF_CORE -- requirements
Module: retospect_lif_core

Interface
REQ-001 SHALL have parameter POT_W, default 6: signed membrane-potential width.
REQ-002 SHALL have parameter REFRACT_CYC, default 2: refractory length in cycles, legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port reset_nn, input, 1: synchronous soft clear of neuron dynamics.
REQ-006 SHALL have port config_en, input, 1: config shift in progress; core frozen.
REQ-007 SHALL have port w1..w4, input, 3 each: signed synapse weights, range -4..3, from the CNB config register.
REQ-008 SHALL have port uT, input, 4: unsigned firing threshold, 0..15.
REQ-009 SHALL have port clockDecaySelect, input, 3: index into clockbus.
REQ-010 SHALL have port clockbus, input, 8: decay ticks from the clockbox; bit0 never ticks, bit1 ticks every cycle.
REQ-011 SHALL have port spike_in, input, 4: presynaptic spikes; bit i gates weight w(i+1).
REQ-012 SHALL have port spike_out, output, 1: one-cycle registered spike pulse.
REQ-013 SHALL have port potential, output, POT_W: registered membrane potential.
REQ-014 SHALL have port spike_count, output, 8: registered fire counter, wraps 255->0.

Function
REQ-015 SHALL implement states INTEGRATE and REFRACT; the state register is exposed to verification only through hierarchy.
REQ-016 SHALL, in INTEGRATE, form syn_sum = sum of the sign-extended weights whose spike_in bit is 1; syn_sum is 5-bit signed, range -16..12.
REQ-017 SHALL compute the decay term as tick = clockbus[clockDecaySelect]: if tick=1, v_d = v moved one step toward 0 (v=0 stays 0); otherwise v_d = v.
REQ-018 SHALL compute v_next = v_d + syn_sum, saturated to the POT_W signed range (default -32..31), with no wrap-around.
REQ-019 SHALL fire when v_next >= uT (signed compare, uT zero-extended): next cycle spike_out=1, potential=0, spike_count+1, state->REFRACT, refractory counter loaded with REFRACT_CYC.
REQ-020 SHALL, when not firing in INTEGRATE, register potential=v_next and spike_out=0.
REQ-021 SHALL, in REFRACT, ignore spike_in and decay, hold potential at 0, keep spike_out=0 after the fire cycle, and decrement the counter; on the cycle the counter reaches 0 it SHALL return to INTEGRATE.
REQ-022 SHALL let uT=0 with v_next >= 0 fire on every INTEGRATE cycle (the "always firing" neuron): the period is REFRACT_CYC+1 cycles.
REQ-023 SHALL, when config_en=1, freeze potential, state, counter and spike_count, and force spike_out=0.
REQ-024 SHALL give reset_nn priority over config_en: on the next cycle potential=0, state=INTEGRATE, counter=0, spike_out=0; spike_count is unchanged.
REQ-025 SHALL resolve simultaneous fire and tick as REQ-017..019: decay, then add, then compare.
REQ-026 SHALL have a latency of exactly 1 cycle from spike_in to spike_out.

Reset
REQ-027 SHALL, on rst_n=0 (asynchronous, at any time including mid-REFRACT), set potential=0, spike_out=0, spike_count=0, state=INTEGRATE and counter=0.
REQ-028 SHALL resume operation on the first rising clk edge after rst_n deasserts.

Structure
REQ-029 SHALL place the state enum, WEIGHT_W=3, THRESH_W=4 and the clockbus index constants in shared package retospect_pkg.
REQ-030 SHALL put the saturating adder in one sub-module, retospect_sat_add.
REQ-031 SHALL be sized at 120-400 lines of RTL, with no latches and all outputs registered.

Verification
REQ-032 SHALL check: w1=3, uT=5, select=0, spike_in=0001 held -> potential 3, then spike_out=1 on cycle 2, potential=0, then 2 cycles refractory.
REQ-033 SHALL check: potential=7, select=1, spike_in=0 -> 6,5,4,... down to 0, then holds 0; starting at -3 -> -2,-1,0.
REQ-034 SHALL check: w1..w4=-4, uT=15, spike_in=1111 -> potential -16, then saturates at -32 and stays there.
REQ-035 SHALL check: reset_nn pulse -> uT=0, select=0, spike_in=0 -> spike_out pulses every 3 cycles; spike_count increments by 1 per pulse and wraps at 255.
REQ-036 SHALL check: config_en=1 mid-integration -> potential frozen and spike_out=0; on release, resumes from the frozen value.
REQ-037 SHALL check: rst_n asserted asynchronously mid-REFRACT -> all outputs 0 immediately, with no clk edge required.

Source files
------------

// File: rtl/retospect_pkg.sv
// Shared constants, state type and helpers for the retospect LIF neuron core.
package retospect_pkg;

    localparam int unsigned WEIGHT_W = 3;   // signed synapse weight, -4..3
    localparam int unsigned THRESH_W = 4;   // unsigned firing threshold, 0..15
    localparam int unsigned NUM_SYN  = 4;   // synapses per neuron
    localparam int unsigned SYN_W    = 5;   // sum of four weights, -16..12
    localparam int unsigned CLKBUS_W = 8;   // decay tick sources from the clockbox
    localparam int unsigned CLKSEL_W = 3;
    localparam int unsigned CNT_W    = 4;   // refractory counter, holds 1..15
    localparam int unsigned COUNT_W  = 8;   // fire counter

    // Fixed clockbus taps: bit 0 never ticks, bit 1 ticks every cycle.
    localparam logic [CLKSEL_W-1:0] CLK_IDX_NEVER = 3'd0;
    localparam logic [CLKSEL_W-1:0] CLK_IDX_EVERY = 3'd1;

    typedef enum logic {
        StIntegrate = 1'b0,
        StRefract   = 1'b1
    } lif_state_e;

    // Sign-extend a raw config weight to the synaptic-sum width.
    function automatic logic signed [SYN_W-1:0] sext_weight(input logic [WEIGHT_W-1:0] w);
        return {{(SYN_W - WEIGHT_W){w[WEIGHT_W-1]}}, w};
    endfunction

endpackage

// File: rtl/retospect_sat_add.sv
// Signed adder that clamps the result to the output width instead of wrapping.
module retospect_sat_add #(
    parameter int unsigned A_W = 6,
    parameter int unsigned B_W = 5,
    parameter int unsigned Y_W = 6
) (
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic signed [Y_W-1:0] y
);

    // Internal width is one bit wider than every operand so the raw sum never overflows.
    localparam int unsigned MAX_IN = (A_W > B_W) ? A_W : B_W;
    localparam int unsigned INT_W  = ((MAX_IN > Y_W) ? MAX_IN : Y_W) + 1;

    localparam logic signed [INT_W-1:0] Y_MAX = {{(INT_W - Y_W + 1){1'b0}}, {(Y_W - 1){1'b1}}};
    localparam logic signed [INT_W-1:0] Y_MIN = {{(INT_W - Y_W + 1){1'b1}}, {(Y_W - 1){1'b0}}};

    logic signed [INT_W-1:0] a_ext;
    logic signed [INT_W-1:0] b_ext;
    logic signed [INT_W-1:0] sum;

    // Full-precision add, then clamp into the Y_W signed range.
    always_comb begin
        a_ext = {{(INT_W - A_W){a[A_W-1]}}, a};
        b_ext = {{(INT_W - B_W){b[B_W-1]}}, b};
        sum   = a_ext + b_ext;
        if (sum > Y_MAX) begin
            y = Y_MAX[Y_W-1:0];
        end else if (sum < Y_MIN) begin
            y = Y_MIN[Y_W-1:0];
        end else begin
            y = sum[Y_W-1:0];
        end
    end

endmodule

// File: rtl/retospect_lif_core.sv
// Leaky integrate-and-fire neuron: four weighted synapses, selectable decay tick,
// threshold fire with a fixed refractory period. All outputs are registered.
module retospect_lif_core
    import retospect_pkg::*;
#(
    parameter int unsigned POT_W       = 6,
    parameter int unsigned REFRACT_CYC = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       reset_nn,
    input  logic                       config_en,
    input  logic        [WEIGHT_W-1:0] w1,
    input  logic        [WEIGHT_W-1:0] w2,
    input  logic        [WEIGHT_W-1:0] w3,
    input  logic        [WEIGHT_W-1:0] w4,
    input  logic        [THRESH_W-1:0] uT,
    input  logic        [CLKSEL_W-1:0] clockDecaySelect,
    input  logic        [CLKBUS_W-1:0] clockbus,
    input  logic         [NUM_SYN-1:0] spike_in,
    output logic                       spike_out,
    output logic signed    [POT_W-1:0] potential,
    output logic         [COUNT_W-1:0] spike_count
);

    // Compare width holds both the signed potential and the zero-extended threshold.
    localparam int unsigned CMP_W = ((POT_W > THRESH_W) ? POT_W : THRESH_W) + 1;
    localparam logic [CNT_W-1:0] REFRACT_LOAD = CNT_W'(REFRACT_CYC);

    lif_state_e                state;
    logic          [CNT_W-1:0] refr_cnt;

    logic signed   [SYN_W-1:0] syn_sum;
    logic signed   [POT_W-1:0] v_decay;
    logic signed   [POT_W-1:0] v_next;
    logic signed   [CMP_W-1:0] v_cmp;
    logic signed   [CMP_W-1:0] ut_cmp;
    logic                      tick;
    logic                      fire;

    // Sum the weights of the synapses that spiked this cycle.
    always_comb begin
        syn_sum = '0;
        if (spike_in[0]) syn_sum = syn_sum + sext_weight(w1);
        if (spike_in[1]) syn_sum = syn_sum + sext_weight(w2);
        if (spike_in[2]) syn_sum = syn_sum + sext_weight(w3);
        if (spike_in[3]) syn_sum = syn_sum + sext_weight(w4);
    end

    assign tick = clockbus[clockDecaySelect];

    // Leak one step toward zero on a decay tick; zero stays zero.
    always_comb begin
        v_decay = potential;
        if (tick && (potential != '0)) begin
            if (potential[POT_W-1]) begin
                v_decay = potential + POT_W'(1);
            end else begin
                v_decay = potential - POT_W'(1);
            end
        end
    end

    // Decay is applied before the synaptic input, so a tick and a fire in the
    // same cycle see the leaked value.
    retospect_sat_add #(
        .A_W (POT_W),
        .B_W (SYN_W),
        .Y_W (POT_W)
    ) u_sat_add (
        .a (v_decay),
        .b (syn_sum),
        .y (v_next)
    );

    assign v_cmp  = {{(CMP_W - POT_W){v_next[POT_W-1]}}, v_next};
    assign ut_cmp = {{(CMP_W - THRESH_W){1'b0}}, uT};
    assign fire   = (v_cmp >= ut_cmp);

    // Neuron FSM with registered outputs; soft clear outranks config freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIntegrate;
            refr_cnt    <= '0;
            potential   <= '0;
            spike_out   <= 1'b0;
            spike_count <= '0;
        end else if (reset_nn) begin
            state     <= StIntegrate;
            refr_cnt  <= '0;
            potential <= '0;
            spike_out <= 1'b0;
        end else if (config_en) begin
            spike_out <= 1'b0;
        end else begin
            unique case (state)
                StIntegrate: begin
                    if (fire) begin
                        state       <= StRefract;
                        refr_cnt    <= REFRACT_LOAD;
                        potential   <= '0;
                        spike_out   <= 1'b1;
                        spike_count <= spike_count + COUNT_W'(1);
                    end else begin
                        potential <= v_next;
                        spike_out <= 1'b0;
                    end
                end
                StRefract: begin
                    potential <= '0;
                    spike_out <= 1'b0;
                    // Leave on the cycle the counter hits zero; guard against a stale zero.
                    if (refr_cnt <= CNT_W'(1)) begin
                        refr_cnt <= '0;
                        state    <= StIntegrate;
                    end else begin
                        refr_cnt <= refr_cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_retospect_lif_core.sv
// Bench for retospect_lif_core: directed scenarios with literal expectations plus
// randomized traffic, all compared against an integer model of the neuron.
module tb_retospect_lif_core;
    import retospect_pkg::*;

    localparam int unsigned POT_W       = 6;
    localparam int unsigned REFRACT_CYC = 2;
    localparam int          PMAX        = (1 <<< (POT_W - 1)) - 1;
    localparam int          PMIN        = -(1 <<< (POT_W - 1));

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      reset_nn;
    logic                      config_en;
    logic        [WEIGHT_W-1:0] w1, w2, w3, w4;
    logic        [THRESH_W-1:0] uT;
    logic        [CLKSEL_W-1:0] sel;
    logic        [CLKBUS_W-1:0] clockbus;
    logic         [NUM_SYN-1:0] spike_in;
    logic                      spike_out;
    logic signed    [POT_W-1:0] potential;
    logic         [COUNT_W-1:0] spike_count;

    int wv [4];
    int checks   = 0;
    int failures = 0;

    // Model state: potential, last spike, fire count, dead cycles still to sit out.
    int m_pot   = 0;
    int m_spike = 0;
    int m_count = 0;
    int m_ref   = 0;

    always #5 clk = ~clk;

    retospect_lif_core #(
        .POT_W       (POT_W),
        .REFRACT_CYC (REFRACT_CYC)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .reset_nn         (reset_nn),
        .config_en        (config_en),
        .w1               (w1),
        .w2               (w2),
        .w3               (w3),
        .w4               (w4),
        .uT               (uT),
        .clockDecaySelect (sel),
        .clockbus         (clockbus),
        .spike_in         (spike_in),
        .spike_out        (spike_out),
        .potential        (potential),
        .spike_count      (spike_count)
    );

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_w(input int a, input int b, input int c, input int d);
        wv[0] = a; wv[1] = b; wv[2] = c; wv[3] = d;
        w1 = 3'(a); w2 = 3'(b); w3 = 3'(c); w4 = 3'(d);
    endtask

    // Advance the model by one clock using the inputs that will be sampled.
    task automatic model_step();
        int syn;
        int vn;
        if (!rst_n) begin
            m_pot = 0; m_spike = 0; m_count = 0; m_ref = 0;
        end else if (reset_nn) begin
            m_pot = 0; m_spike = 0; m_ref = 0;
        end else if (config_en) begin
            m_spike = 0;
        end else if (m_ref > 0) begin
            m_ref   = m_ref - 1;
            m_spike = 0;
            m_pot   = 0;
        end else begin
            vn = m_pot;
            if (clockbus[sel]) vn = (vn > 0) ? vn - 1 : ((vn < 0) ? vn + 1 : 0);
            syn = 0;
            for (int i = 0; i < 4; i++) if (spike_in[i]) syn += wv[i];
            vn = vn + syn;
            if (vn > PMAX) vn = PMAX;
            if (vn < PMIN) vn = PMIN;
            if (vn >= int'(uT)) begin
                m_pot   = 0;
                m_spike = 1;
                m_count = (m_count + 1) % 256;
                m_ref   = int'(REFRACT_CYC);
            end else begin
                m_pot   = vn;
                m_spike = 0;
            end
        end
    endtask

    task automatic compare();
        chk("model_potential", 32'(potential), m_pot);
        chk("model_spike_out", 32'(spike_out), m_spike);
        chk("model_spike_count", 32'(spike_count), m_count);
    endtask

    // One clock: update model, let the DUT take the edge, compare just after it.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #2;
        compare();
    endtask

    task automatic soft_clear();
        reset_nn = 1'b1;
        cyc();
        reset_nn = 1'b0;
    endtask

    // Pull rst_n low between edges and check that outputs clear with no clock.
    task automatic async_reset(input string tag);
        #1 rst_n = 1'b0;
        #1;
        m_pot = 0; m_spike = 0; m_count = 0; m_ref = 0;
        chk({tag, "_potential"}, 32'(potential), 0);
        chk({tag, "_spike_out"}, 32'(spike_out), 0);
        chk({tag, "_spike_count"}, 32'(spike_count), 0);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        int r;
        rst_n = 1'b0; reset_nn = 1'b0; config_en = 1'b0;
        set_w(0, 0, 0, 0);
        uT = '0; sel = CLK_IDX_NEVER; clockbus = 8'b0000_0010; spike_in = '0;
        #3;
        chk("reset_potential", 32'(potential), 0);
        chk("reset_spike_out", 32'(spike_out), 0);
        chk("reset_spike_count", 32'(spike_count), 0);
        #9 rst_n = 1'b1;

        // Integrate to threshold, fire, two refractory cycles, integrate again.
        set_w(3, 0, 0, 0); uT = 4'd5; sel = CLK_IDX_NEVER; spike_in = 4'b0001;
        cyc(); chk("fire_c1_potential", 32'(potential), 3);
        chk("fire_c1_spike", 32'(spike_out), 0);
        cyc(); chk("fire_c2_spike", 32'(spike_out), 1);
        chk("fire_c2_potential", 32'(potential), 0);
        chk("fire_c2_count", 32'(spike_count), 1);
        cyc(); chk("refr1_potential", 32'(potential), 0);
        chk("refr1_spike", 32'(spike_out), 0);
        cyc(); chk("refr2_potential", 32'(potential), 0);
        cyc(); chk("post_refr_potential", 32'(potential), 3);

        // Decay toward zero from both signs.
        soft_clear();
        set_w(3, 3, 1, 0); uT = 4'd15; spike_in = 4'b0111; sel = CLK_IDX_NEVER;
        cyc(); chk("decay_start", 32'(potential), 7);
        spike_in = '0; sel = CLK_IDX_EVERY;
        for (int k = 6; k >= 0; k--) begin
            cyc(); chk("decay_pos", 32'(potential), k);
        end
        repeat (2) begin
            cyc(); chk("decay_hold_zero", 32'(potential), 0);
        end
        set_w(-3, 0, 0, 0); spike_in = 4'b0001; sel = CLK_IDX_NEVER;
        cyc(); chk("decay_neg_start", 32'(potential), -3);
        spike_in = '0; sel = CLK_IDX_EVERY;
        for (int k = -2; k <= 0; k++) begin
            cyc(); chk("decay_neg", 32'(potential), k);
        end

        // Negative saturation, then soft clear wins over config freeze.
        soft_clear();
        set_w(-4, -4, -4, -4); uT = 4'd15; spike_in = 4'b1111; sel = CLK_IDX_NEVER;
        cyc(); chk("sat_first", 32'(potential), -16);
        repeat (4) begin
            cyc(); chk("sat_hold", 32'(potential), -32);
        end
        config_en = 1'b1; reset_nn = 1'b1;
        cyc(); chk("clear_over_config", 32'(potential), 0);
        config_en = 1'b0; reset_nn = 1'b0;

        // Config freeze mid-integration.
        set_w(2, 0, 0, 0); spike_in = 4'b0001; uT = 4'd15; sel = CLK_IDX_NEVER;
        cyc(); chk("cfg_pre1", 32'(potential), 2);
        cyc(); chk("cfg_pre2", 32'(potential), 4);
        config_en = 1'b1;
        repeat (3) begin
            cyc(); chk("cfg_frozen_pot", 32'(potential), 4);
            chk("cfg_frozen_spike", 32'(spike_out), 0);
        end
        config_en = 1'b0;
        cyc(); chk("cfg_resume", 32'(potential), 6);
        async_reset("arst_integrate");
        uT = '0; spike_in = '0; config_en = 1'b1;
        cyc(); chk("cfg_blocks_fire", 32'(spike_out), 0);
        chk("cfg_blocks_count", 32'(spike_count), 0);
        config_en = 1'b0;
        cyc(); chk("cfg_release_fire", 32'(spike_out), 1);

        // Async reset right after a fire, while refractory.
        soft_clear();
        cyc(); chk("pre_arst_spike", 32'(spike_out), 1);
        chk("pre_arst_count", 32'(spike_count), 2);
        async_reset("arst_refract");

        // Always-firing neuron: period 3, counter wraps after 256 pulses.
        uT = '0; sel = CLK_IDX_NEVER; spike_in = '0;
        soft_clear();
        for (int n = 0; n < 768; n++) begin
            cyc();
            chk("always_fire_spike", 32'(spike_out), ((n % 3) == 0) ? 1 : 0);
            chk("always_fire_count", 32'(spike_count), ((n / 3) + 1) % 256);
        end
        chk("count_wrapped", 32'(spike_count), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 2500; n++) begin
            r = int'($urandom());
            set_w(int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 7)) - 4,
                  int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 7)) - 4);
            uT        = 4'($urandom_range(0, 15));
            sel       = 3'($urandom_range(0, 7));
            clockbus  = {r[7:2], 2'b10};
            spike_in  = r[11:8];
            reset_nn  = ($urandom_range(0, 31) == 0);
            config_en = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #1 rst_n = 1'b0;
            end
            cyc();
            rst_n = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
